// File: rtl/led_period_meter_pkg.sv
// led_period_meter_pkg: shared types and defaults for the period meter.
// Holds the FSM state enum and the default CNT_W / T_TIMEOUT values.
package led_period_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int CNT_W_DEF     = 26;
  localparam int T_TIMEOUT_DEF = 50000000;

endpackage

// File: rtl/led_period_meter_sig_edge_sync.sv
// sig_edge_sync: synchronizer, optional glitch filter and rise detector.
// Ports: CLK, RST (sync, active-high), SIG_IN (async), RISE (1-cycle).
// Optional macro GLITCH_FILTER_EN adds a 3-sample majority filter
// after the synchronizer (+2 cycles latency, drops 1-cycle glitches).
module sig_edge_sync (
  input  logic CLK,
  input  logic RST,
  input  logic SIG_IN,
  output logic RISE
);

  logic sync1;
  logic sync2;
  logic sync3;

`ifdef GLITCH_FILTER_EN
  logic tap1;
  logic tap2;
  logic filt;
  logic maj;

  // Two of the last three synchronized samples must agree.
  assign maj = (sync2 & tap1) | (sync2 & tap2) | (tap1 & tap2);

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      tap1  <= 1'b0;
      tap2  <= 1'b0;
      filt  <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= SIG_IN;
      sync2 <= sync1;
      tap1  <= sync2;
      tap2  <= tap1;
      filt  <= maj;
      sync3 <= filt;
    end
  end

  assign RISE = filt & ~sync3;
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= SIG_IN;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // sync3 resets low, so a level already high at release counts.
  assign RISE = sync2 & ~sync3;
`endif

endmodule

// File: rtl/led_period_meter.sv
// led_period_meter: measures rising-to-rising period of SIG_IN in CLK
// cycles. Ports: CLK, RST (sync, active-high), SIG_IN (async),
// PERIOD (last period), PERIOD_VALID (1-cycle pulse on update),
// NO_SIGNAL (high while no valid period held), LED (count mod 16).
// Params: CNT_W, T_TIMEOUT (2 <= T_TIMEOUT < 2**CNT_W).
// Optional macro GLITCH_FILTER_EN enables the input majority filter.
module led_period_meter
  import led_period_meter_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int T_TIMEOUT = T_TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SIG_IN,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID,
  output logic             NO_SIGNAL,
  output logic [3:0]       LED
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_TIMEOUT - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             at_limit;
  logic             arm;
  logic             report;
  logic             expire;
  logic             tick;

  sig_edge_sync u_sync (
    .CLK    (CLK),
    .RST    (RST),
    .SIG_IN (SIG_IN),
    .RISE   (rise)
  );

  // cnt stops at CNT_LAST, so it can never wrap.
  assign at_limit = (cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (rise) next_state = MEASURE;
      MEASURE: if (!rise && at_limit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A rise on the final count still reports (rise beats timeout).
  always_comb begin
    arm    = 1'b0;
    report = 1'b0;
    expire = 1'b0;
    tick   = 1'b0;
    unique case (state)
      IDLE: arm = rise;
      MEASURE: begin
        if (rise)          report = 1'b1;
        else if (at_limit) expire = 1'b1;
        else               tick   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt          <= '0;
      PERIOD       <= '0;
      PERIOD_VALID <= 1'b0;
      NO_SIGNAL    <= 1'b1;
      LED          <= 4'd0;
    end else begin
      PERIOD_VALID <= report;
      if (arm || report) cnt <= '0;
      else if (tick)     cnt <= cnt + 1'b1;
      if (report) begin
        PERIOD    <= cnt + 1'b1;
        LED       <= LED + 4'd1;
        NO_SIGNAL <= 1'b0;
      end
      if (expire) NO_SIGNAL <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_period_meter.sv
// tb_led_period_meter: table vectors, hand sequences and random waves
// checked every cycle against a timestamp-based reference model.
module tb_led_period_meter;

  localparam int CW = 16;
  localparam int TT = 100;
`ifdef GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int D    = 3;
  localparam int LAT  = 4;
`else
  localparam bit FILT = 1'b0;
  localparam int D    = 2;
  localparam int LAT  = 2;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          SIG_IN = 1'b0;
  logic [CW-1:0] PERIOD;
  logic          PERIOD_VALID;
  logic          NO_SIGNAL;
  logic [3:0]    LED;

  led_period_meter #(.CNT_W(CW), .T_TIMEOUT(TT)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SIG_IN       (SIG_IN),
    .PERIOD       (PERIOD),
    .PERIOD_VALID (PERIOD_VALID),
    .NO_SIGNAL    (NO_SIGNAL),
    .LED          (LED)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int q[$];

  // Reference model: sample history, detected-rise timestamps.
  bit     s_h[3];
  bit     d_h[5];
  bit     armed;
  longint edge_n = 0;
  longint last;
  longint m_period;
  int     m_led;
  bit     m_valid;
  bit     m_ns;

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d",
               name, edge_n, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s);
    bit dn;
    bit rise;
    edge_n++;
    m_valid = 1'b0;
    if (r) begin
      for (int i = 0; i < 3; i++) s_h[i] = 1'b0;
      for (int i = 0; i < 5; i++) d_h[i] = 1'b0;
      armed    = 1'b0;
      m_period = 0;
      m_led    = 0;
      m_ns     = 1'b1;
      return;
    end
    s_h[2] = s_h[1];
    s_h[1] = s_h[0];
    s_h[0] = s;
    if (FILT)
      dn = (s_h[0] & s_h[1]) | (s_h[0] & s_h[2]) | (s_h[1] & s_h[2]);
    else
      dn = s;
    for (int i = 4; i > 0; i--) d_h[i] = d_h[i-1];
    d_h[0] = dn;
    rise = d_h[D] && !d_h[D+1];
    if (rise) begin
      if (armed) begin
        m_period = edge_n - last;
        m_led    = (m_led + 1) % 16;
        m_valid  = 1'b1;
        m_ns     = 1'b0;
      end
      armed = 1'b1;
      last  = edge_n;
    end else if (armed && (edge_n - last == TT)) begin
      armed = 1'b0;
      m_ns  = 1'b1;
    end
  endtask

  task automatic tick(input bit r, input bit s);
    RST    = r;
    SIG_IN = s;
    @(posedge CLK);
    model_step(r, s);
    @(negedge CLK);
    check("period", PERIOD, m_period);
    check("valid", PERIOD_VALID, m_valid);
    check("no_signal", NO_SIGNAL, m_ns);
    check("led", LED, m_led);
    if (PERIOD_VALID) q.push_back(int'(PERIOD));
  endtask

  task automatic do_reset(input bit s);
    for (int i = 0; i < 3; i++) tick(1'b1, s);
    q.delete();
  endtask

  task automatic square(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < per; c++) tick(1'b0, c < hi);
  endtask

  typedef struct {
    int per;
    int n;
    int e_period;
    int e_led;
    bit e_ns;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{10,  4, 10,  3, 1'b0};
    tbl[1] = '{8,  17,  8,  0, 1'b0};
    tbl[2] = '{8,  18,  8,  1, 1'b0};
    tbl[3] = '{20,  1,  0,  0, 1'b1};
    tbl[4] = '{37,  3, 37,  2, 1'b0};
    tbl[5] = '{100, 2, 100, 1, 1'b0};
    tbl[6] = '{101, 2,  0,  0, 1'b1};

    do_reset(1'b0);
    check("rst_period", PERIOD, 0);
    check("rst_valid", PERIOD_VALID, 0);
    check("rst_no_signal", NO_SIGNAL, 1);
    check("rst_led", LED, 0);

    foreach (tbl[i]) begin
      do_reset(1'b0);
      tick(1'b0, 1'b0);
      square(tbl[i].per, tbl[i].per / 2, tbl[i].n);
      check($sformatf("tbl%0d_period", i), PERIOD, tbl[i].e_period);
      check($sformatf("tbl%0d_led", i), LED, tbl[i].e_led);
      check($sformatf("tbl%0d_ns", i), NO_SIGNAL, tbl[i].e_ns);
      check($sformatf("tbl%0d_reports", i), q.size(),
            (tbl[i].n - 1 > 0) && (tbl[i].per <= TT) ?
            tbl[i].n - 1 : 0);
    end

    // Timeout latency after the arming rise.
    begin
      int waited;
      do_reset(1'b0);
      square(10, 5, 3);
      q.delete();
      waited = 0;
      while (!NO_SIGNAL && waited < 200) begin
        tick(1'b0, 1'b0);
        waited++;
      end
      check("timeout_latency", waited, 91 + LAT);
      repeat (20) tick(1'b0, 1'b0);
      check("timeout_period", PERIOD, 10);
      check("timeout_led", LED, 2);
      check("timeout_pulses", q.size(), 0);
    end

    // Reset in the low phase of a period-20 wave.
    do_reset(1'b0);
    square(20, 10, 2);
    for (int c = 0; c < 14; c++) tick(1'b0, c < 10);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("midrst_period", PERIOD, 0);
    check("midrst_led", LED, 0);
    check("midrst_ns", NO_SIGNAL, 1);
    q.delete();
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b0);
    square(20, 10, 3);
    check("midrst_count", q.size(), 2);
    if (q.size() > 0) check("midrst_first", q[0], 20);

    // Level high at reset release arms immediately.
    do_reset(1'b1);
    for (int c = 0; c < 10; c++) tick(1'b0, c < 5);
    check("hi_release_ns", NO_SIGNAL, 1);
    check("hi_release_none", q.size(), 0);
    square(10, 5, 2);
    check("hi_release_count", q.size(), 2);
    if (q.size() > 0) check("hi_release_first", q[0], 10);

    // One-cycle glitch inside the second period-40 cycle.
    do_reset(1'b0);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 40; c++)
        tick(1'b0, (c < 20) || (k == 1 && c == 30));
    if (FILT) begin
      check("glitch_count", q.size(), 2);
      if (q.size() == 2) check("glitch_period", q[1], 40);
    end else begin
      check("glitch_count", q.size(), 3);
      if (q.size() == 3) begin
        check("glitch_first", q[1], 30);
        check("glitch_sum", q[1] + q[2], 40);
      end
    end

    // Random waves, occasional resets, model-checked every cycle.
    do_reset(1'(($urandom & 1)));
    for (int k = 0; k < 60; k++) begin
      int per;
      int hi;
      per = $urandom_range(140, 3);
      hi  = $urandom_range(per - 1, 1);
      if ($urandom_range(14, 0) == 0)
        tick(1'b1, 1'(($urandom & 1)));
      square(per, hi, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_period_meter.md
LED_PERIOD_METER -- requirements
Module: led_period_meter

Interface
REQ-001 Parameter CNT_W, default 26: width of the period counter and the PERIOD output.
REQ-002 Parameter T_TIMEOUT, default 50000000: CLK cycles without a rising edge before the input is declared dead (1 s at 50 MHz).
REQ-003 Port CLK, input, 1: single system clock; all state on its rising edge.
REQ-004 Port RST, input, 1: reset, synchronous, active-high.
REQ-005 Port SIG_IN, input, 1: asynchronous square wave to measure, e.g. a divided LED toggle.
REQ-006 Port PERIOD, output, CNT_W: last measured rising-to-rising period in CLK cycles.
REQ-007 Port PERIOD_VALID, output, 1: one-cycle pulse when PERIOD is updated.
REQ-008 Port NO_SIGNAL, output, 1: level, high while no valid period is held.
REQ-009 Port LED, output, 4: count of completed measurements, modulo 16.

Function
REQ-010 SIG_IN SHALL pass through a 2-flop synchronizer, then a third flop for edge detection; rise = sync2 & ~sync3.
REQ-011 Rise detection SHALL occur 3 CLK edges after SIG_IN goes high (before the filter of REQ-024).
REQ-012 FSM states SHALL be IDLE and MEASURE; reset state is IDLE.
REQ-013 IDLE: on rise -> MEASURE, cnt <= 0; otherwise hold, cnt static.
REQ-014 MEASURE, rise: PERIOD <= cnt+1, PERIOD_VALID = 1 next cycle, cnt <= 0, LED <= LED+1 (wraps 15->0), NO_SIGNAL <= 0; stay in MEASURE.
REQ-015 MEASURE, no rise, cnt == T_TIMEOUT-1: -> IDLE, NO_SIGNAL <= 1; PERIOD and LED hold last value, no PERIOD_VALID pulse.
REQ-016 MEASURE, no rise, cnt < T_TIMEOUT-1: cnt <= cnt+1.
REQ-017 Rise and timeout in the same cycle: rise wins; a valid period of T_TIMEOUT SHALL be reported.
REQ-018 cnt SHALL never wrap; T_TIMEOUT SHALL satisfy 2 <= T_TIMEOUT < 2^CNT_W.
REQ-019 PERIOD_VALID SHALL be high for exactly one cycle per measurement, never in two consecutive cycles.
REQ-020 Falling edges SHALL NOT affect any state; duty cycle does not matter.

Reset
REQ-021 While RST is high at a CLK edge: state IDLE, cnt 0, PERIOD 0, PERIOD_VALID 0, NO_SIGNAL 1, LED 0, and the synchronizer and filter flops 0.
REQ-022 Reset asserted mid-measurement SHALL discard the partial count; the first rise after reset SHALL only arm (IDLE -> MEASURE), not report.
REQ-023 A SIG_IN high level present at reset release SHALL count as a rise when it reaches sync2, because sync3 resets to 0.

Configuration
REQ-024 With GLITCH_FILTER_EN defined, sync2 SHALL feed a 3-sample majority filter; its output replaces sync2 in edge detection, adding 2 cycles of rise latency (5 total) and rejecting single-cycle glitches.
REQ-025 Without GLITCH_FILTER_EN, no filter is present and latency is per REQ-011; a 1-cycle glitch SHALL count as a rise.

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE, MEASURE) and the default CNT_W and T_TIMEOUT constants.
REQ-027 Synchronizer, optional filter and edge detector SHALL be one sub-module, sig_edge_sync, with ports CLK, RST, SIG_IN and RISE.

Verification
REQ-028 Reset, then SIG_IN square wave of period 10 CLK -> first rise arms only; each later rise gives PERIOD=10, PERIOD_VALID 1-cycle pulse, NO_SIGNAL=0, LED increments 1,2,3...
REQ-029 T_TIMEOUT=100, one rise then SIG_IN held low -> NO_SIGNAL=1 exactly 100 cycles after the arming rise, PERIOD unchanged, no pulse.
REQ-030 T_TIMEOUT=100, second rise detected when cnt=99 -> PERIOD=100, PERIOD_VALID=1, NO_SIGNAL=0.
REQ-031 Run 17 periods of 8 CLK -> LED goes 15 -> 0 -> 1; PERIOD=8 throughout.
REQ-032 RST pulsed mid-period during a period-20 wave -> all outputs return to reset values; first report after release is PERIOD=20, never a partial value.
REQ-033 1-cycle high glitch inside a period-40 wave -> with GLITCH_FILTER_EN, PERIOD=40; without it, two shorter periods are reported whose sum is 40.
